pipelined_oet_sorter: RTL and testbench

//  Parametrised pipelined sorter: sorts N lanes of WIDTH-bit values using an odd-even transposition network.

---
 rtl/sorter_pkg.sv | 11 +
 rtl/pipelined_oet_sorter_if.sv | 31 +++
 rtl/sort_cmp_swap.sv | 30 +++
 rtl/pipelined_oet_sorter.sv | 130 +++++++++++++
 tb/tb_pipelined_oet_sorter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
package sorter_pkg;

  typedef enum logic {Asc = 1'b0, Desc = 1'b1} order_e;

  // Width of an original-lane index; never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipelined_oet_sorter_if.sv
// Vector handshake bundle for pipelined_oet_sorter.
// out_tag exists only when SORT_TAG_EN is defined.
interface pipelined_oet_sorter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
) ();
  import sorter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_desc;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
`ifdef SORT_TAG_EN
  localparam int unsigned TagW = tag_w(N);
  logic [N*TagW-1:0]  out_tag;

  modport slave (input in_valid, in_desc, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_tag);
  modport master (output in_valid, in_desc, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_tag);
`else
  modport slave (input in_valid, in_desc, in_data, out_ready,
                 output in_ready, out_valid, out_data);
  modport master (output in_valid, in_desc, in_data, out_ready,
                  input in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange of one lane pair; swaps only on strict order violation.
module sort_cmp_swap import sorter_pkg::*; #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  logic a_gt_b, a_lt_b;

  always_comb begin
    if (SIGNED) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    // Equal keys never swap, which keeps the sort stable.
    swapped = (desc == Desc) ? a_lt_b : a_gt_b;
    lo      = swapped ? b : a;
    hi      = swapped ? a : b;
  end

endmodule

// File: rtl/pipelined_oet_sorter.sv
// N-stage odd-even transposition sorter with valid/ready flow control.
// Define SORT_TAG_EN to carry the original lane index of every element to out_tag.
module pipelined_oet_sorter import sorter_pkg::*; #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N      = 8,
  parameter bit          SIGNED = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_oet_sorter_if.slave bus
);

  logic             valid_q [N];
  logic             desc_q  [N];
  logic [WIDTH-1:0] data_q  [N][N];
  logic             valid_d [N];
  logic             desc_d  [N];
  logic [WIDTH-1:0] data_in [N][N];
  logic [WIDTH-1:0] data_d  [N][N];
  logic             adv;
`ifdef SORT_TAG_EN
  localparam int unsigned TagW = tag_w(N);
  logic [TagW-1:0]  tag_q   [N][N];
  logic [TagW-1:0]  tag_in  [N][N];
  logic [TagW-1:0]  tag_d   [N][N];
`endif

  // The whole pipe moves in lockstep; only a stalled valid output freezes it.
  assign adv           = ~valid_q[N-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[N-1];

  logic unused_desc;
  assign unused_desc = desc_q[N-1];

  always_comb begin
    valid_d[0] = bus.in_valid;
    desc_d[0]  = bus.in_desc;
    for (int unsigned k = 0; k < N; k++) begin
      data_in[0][k] = bus.in_data[k*WIDTH +: WIDTH];
`ifdef SORT_TAG_EN
      tag_in[0][k]  = TagW'(k);
`endif
    end
    for (int unsigned s = 1; s < N; s++) begin
      valid_d[s] = valid_q[s-1];
      desc_d[s]  = desc_q[s-1];
      for (int unsigned k = 0; k < N; k++) begin
        data_in[s][k] = data_q[s-1][k];
`ifdef SORT_TAG_EN
        tag_in[s][k]  = tag_q[s-1][k];
`endif
      end
    end
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    for (genvar k = 0; k < N; k++) begin : g_lane
      if (((k % 2) == (s % 2)) && (k < int'(N) - 1)) begin : g_pair
        logic             swapped;
        logic [WIDTH-1:0] lo, hi;
        sort_cmp_swap #(
          .WIDTH (WIDTH),
          .SIGNED(SIGNED)
        ) u_cmp (
          .a      (data_in[s][k]),
          .b      (data_in[s][k+1]),
          .desc   (desc_d[s]),
          .lo     (lo),
          .hi     (hi),
          .swapped(swapped)
        );
        assign data_d[s][k]   = lo;
        assign data_d[s][k+1] = hi;
`ifdef SORT_TAG_EN
        assign tag_d[s][k]    = swapped ? tag_in[s][k+1] : tag_in[s][k];
        assign tag_d[s][k+1]  = swapped ? tag_in[s][k]   : tag_in[s][k+1];
`else
        logic unused_swapped;
        assign unused_swapped = swapped;
`endif
      end else if (((k % 2) != (s % 2)) ? (k == 0) : (k == int'(N) - 1)) begin : g_pass
        // Edge lanes left unpaired on odd stages.
        assign data_d[s][k] = data_in[s][k];
`ifdef SORT_TAG_EN
        assign tag_d[s][k]  = tag_in[s][k];
`endif
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q[s] <= 1'b0;
        desc_q[s]  <= 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
          data_q[s][k] <= '0;
`ifdef SORT_TAG_EN
          tag_q[s][k]  <= '0;
`endif
        end
      end else if (adv) begin
        valid_q[s] <= valid_d[s];
        desc_q[s]  <= desc_d[s];
        for (int unsigned k = 0; k < N; k++) begin
          data_q[s][k] <= data_d[s][k];
`ifdef SORT_TAG_EN
          tag_q[s][k]  <= tag_d[s][k];
`endif
        end
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = data_q[N-1][k];
    end
  end

`ifdef SORT_TAG_EN
  always_comb begin
    bus.out_tag = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.out_tag[k*TagW +: TagW] = tag_q[N-1][k];
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_oet_sorter.sv
// Directed self-checking bench for pipelined_oet_sorter (N=8, WIDTH=8), unsigned and signed builds.
module tb_pipelined_oet_sorter;

  localparam int unsigned W  = 8;
  localparam int unsigned NL = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_oet_sorter_if #(.WIDTH(W), .N(NL)) u_if ();
  pipelined_oet_sorter_if #(.WIDTH(W), .N(NL)) s_if ();

  pipelined_oet_sorter #(.WIDTH(W), .N(NL), .SIGNED(1'b0)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  pipelined_oet_sorter #(.WIDTH(W), .N(NL), .SIGNED(1'b1)) s_dut (
    .clk(clk),
    .rst(rst),
    .bus(s_if.slave)
  );

  // Stable insertion sort reference.
  function automatic void model(input logic [63:0] din, input bit desc, input bit sgn,
                                output logic [63:0] dout, output logic [23:0] tout);
    int v[8];
    int t[8];
    int tmp;
    for (int k = 0; k < 8; k++) begin
      v[k] = int'(din[k*8 +: 8]);
      if (sgn && v[k] > 127) v[k] = v[k] - 256;
      t[k] = k;
    end
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (v[j] > v[j-1]) : (v[j] < v[j-1])) begin
          tmp = v[j]; v[j] = v[j-1]; v[j-1] = tmp;
          tmp = t[j]; t[j] = t[j-1]; t[j-1] = tmp;
        end else begin
          break;
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      tmp = v[k];
      dout[k*8 +: 8] = tmp[7:0];
      tmp = t[k];
      tout[k*3 +: 3] = tmp[2:0];
    end
  endfunction

  function automatic logic [63:0] bp_vec(input int i);
    logic [63:0] v;
    int          x;
    for (int k = 0; k < 8; k++) begin
      x = (i * 37 + k * 91 + 13) & 255;
      v[k*8 +: 8] = x[7:0];
    end
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic get_tag(input bit sgn, output logic [23:0] ot);
`ifdef SORT_TAG_EN
    ot = sgn ? s_if.out_tag : u_if.out_tag;
`else
    ot = '0;
`endif
  endtask

  // Issue one vector into an idle pipe and wait for its result.
  task automatic send_wait(input bit sgn, input logic [63:0] d, input bit desc,
                           output logic [63:0] od, output logic [23:0] ot, output int lat);
    if (sgn) begin
      s_if.in_valid = 1'b1; s_if.in_data = d; s_if.in_desc = desc;
    end else begin
      u_if.in_valid = 1'b1; u_if.in_data = d; u_if.in_desc = desc;
    end
    cycle();
    s_if.in_valid = 1'b0;
    u_if.in_valid = 1'b0;
    lat = 1;
    while (!(sgn ? s_if.out_valid : u_if.out_valid) && lat < 20) begin
      cycle();
      lat++;
    end
    od = sgn ? s_if.out_data : u_if.out_data;
    get_tag(sgn, ot);
  endtask

  task automatic test_reset();
    logic [23:0] ot;
    #12;
    n_cmp++;
    if (u_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", u_if.out_valid);
    end
    n_cmp++;
    if (u_if.out_data !== 64'h0) begin
      n_bad++; $display("FAIL reset_out_data got %h want 0", u_if.out_data);
    end
    n_cmp++;
    if (u_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 1", u_if.in_ready);
    end
    get_tag(1'b0, ot);
    n_cmp++;
    if (ot !== 24'h0) begin
      n_bad++; $display("FAIL reset_out_tag got %h want 0", ot);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_sort_basic();
    logic [63:0] din [3];
    logic        dsc [3];
    logic [63:0] wd  [3];
    logic [23:0] wt  [3];
    logic [63:0] od;
    logic [23:0] ot;
    int          lat;
    din[0] = 64'h0706050403020100; dsc[0] = 1'b0;
    wd[0]  = 64'h0706050403020100;
    wt[0]  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    din[1] = 64'h0001020304050607; dsc[1] = 1'b0;
    wd[1]  = 64'h0706050403020100;
    wt[1]  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    din[2] = 64'h0602090501040103; dsc[2] = 1'b1;  // lanes 0..7 = 3,1,4,1,5,9,2,6
    wd[2]  = 64'h0101020304050609;
    wt[2]  = {3'd3, 3'd1, 3'd6, 3'd0, 3'd2, 3'd4, 3'd7, 3'd5};
    for (int i = 0; i < 3; i++) begin
      send_wait(1'b0, din[i], dsc[i], od, ot, lat);
      n_cmp++;
      if (lat != 8) begin
        n_bad++; $display("FAIL basic%0d_latency got %0d want 8", i, lat);
      end
      n_cmp++;
      if (od !== wd[i]) begin
        n_bad++; $display("FAIL basic%0d_data got %h want %h", i, od, wd[i]);
      end
`ifdef SORT_TAG_EN
      n_cmp++;
      if (ot !== wt[i]) begin
        n_bad++; $display("FAIL basic%0d_tag got %h want %h", i, ot, wt[i]);
      end
`endif
    end
  endtask

  task automatic test_stability();
    logic [63:0] od;
    logic [23:0] ot;
    logic [23:0] wt;
    int          lat;
    // lanes 0..7 = 5,5,2,5,1,7,0,3; the three 5s come from lanes 0,1,3
    wt = {3'd5, 3'd3, 3'd1, 3'd0, 3'd7, 3'd2, 3'd4, 3'd6};
    send_wait(1'b0, 64'h0300070105020505, 1'b0, od, ot, lat);
    n_cmp++;
    if (od !== 64'h0705050503020100) begin
      n_bad++; $display("FAIL stable_data got %h want 0705050503020100", od);
    end
`ifdef SORT_TAG_EN
    n_cmp++;
    if (ot !== wt) begin
      n_bad++; $display("FAIL stable_tag got %h want %h", ot, wt);
    end
`else
    if (wt == 24'h0) $display("tags not built");
`endif
  endtask

  task automatic test_signed();
    logic [63:0] od;
    logic [23:0] ot;
    int          lat;
    // lanes 0..7 = 80,7F,00,FF,01,FE,40,C0
    send_wait(1'b1, 64'hC040FE01FF007F80, 1'b0, od, ot, lat);
    n_cmp++;
    if (od !== 64'h7F400100FFFEC080) begin
      n_bad++; $display("FAIL signed_data got %h want 7F400100FFFEC080", od);
    end
    n_cmp++;
    if (od[7:0] !== 8'h80 || od[63:56] !== 8'h7F) begin
      n_bad++; $display("FAIL signed_ends got %h/%h want 80/7F", od[7:0], od[63:56]);
    end
    send_wait(1'b0, 64'hC040FE01FF007F80, 1'b0, od, ot, lat);
    n_cmp++;
    if (od !== 64'hFFFEC0807F400100) begin
      n_bad++; $display("FAIL unsigned_data got %h want FFFEC0807F400100", od);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d [$];
    logic [23:0] exp_t [$];
    logic [63:0] d, ed;
    logic [23:0] et, ot;
    int          sent = 0;
    int          got  = 0;
    int          first = -1;
    u_if.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sent < 20) begin
        d = {$urandom(), $urandom()};
        u_if.in_valid = 1'b1; u_if.in_data = d; u_if.in_desc = sent[0];
      end else begin
        u_if.in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (u_if.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, u_if.in_ready);
      end
      if (u_if.out_valid === 1'b1) begin
        if (first < 0) first = c;
        n_cmp++;
        if (c != first + got || exp_d.size() == 0) begin
          n_bad++; $display("FAIL b2b_cadence cycle %0d got output %0d want cycle %0d", c, got,
                            first + got);
        end else begin
          ed = exp_d.pop_front();
          et = exp_t.pop_front();
          get_tag(1'b0, ot);
          n_cmp++;
          if (u_if.out_data !== ed) begin
            n_bad++; $display("FAIL b2b_data #%0d got %h want %h", got, u_if.out_data, ed);
          end
`ifdef SORT_TAG_EN
          n_cmp++;
          if (ot !== et) begin
            n_bad++; $display("FAIL b2b_tag #%0d got %h want %h", got, ot, et);
          end
`endif
        end
        got++;
      end
      if (u_if.in_valid && u_if.in_ready) begin
        model(d, sent[0], 1'b0, ed, et);
        exp_d.push_back(ed);
        exp_t.push_back(et);
        sent++;
      end
      cycle();
    end
    u_if.in_valid = 1'b0;
    n_cmp++;
    if (first != 8) begin
      n_bad++; $display("FAIL b2b_first_out got cycle %0d want 8", first);
    end
    n_cmp++;
    if (got != 20) begin
      n_bad++; $display("FAIL b2b_count got %0d want 20", got);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d [$];
    logic [63:0] ed, et_d, held;
    logic [23:0] et;
    int          idx = 0;
    int          got = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      u_if.out_ready = !(c >= 10 && c < 15);
      if (idx < 12) begin
        u_if.in_valid = 1'b1; u_if.in_data = bp_vec(idx); u_if.in_desc = idx[0];
      end else begin
        u_if.in_valid = 1'b0;
      end
      #1;
      if (c >= 10 && c < 15) begin
        n_cmp++;
        if (u_if.in_ready !== 1'b0) begin
          n_bad++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, u_if.in_ready);
        end
        if (c == 10) held = u_if.out_data;
        else begin
          n_cmp++;
          if (u_if.out_data !== held || u_if.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_hold cycle %0d got %h/%b want %h/1", c, u_if.out_data,
                              u_if.out_valid, held);
          end
        end
      end
      if (u_if.out_valid === 1'b1 && u_if.out_ready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_bad++; $display("FAIL bp_extra cycle %0d got %h want none", c, u_if.out_data);
        end else begin
          ed = exp_d.pop_front();
          if (u_if.out_data !== ed) begin
            n_bad++; $display("FAIL bp_data #%0d got %h want %h", got, u_if.out_data, ed);
          end
        end
        got++;
      end
      if (u_if.in_valid && u_if.in_ready) begin
        model(bp_vec(idx), idx[0], 1'b0, et_d, et);
        exp_d.push_back(et_d);
        idx++;
      end
      cycle();
    end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    n_cmp++;
    if (got != 12 || exp_d.size() != 0) begin
      n_bad++; $display("FAIL bp_count got %0d left %0d want 12 left 0", got, exp_d.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] od;
    logic [23:0] ot;
    int          lat;
    int          stray = 0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.in_valid = 1'b1; u_if.in_data = bp_vec(i + 50); u_if.in_desc = 1'b0;
      cycle();
    end
    u_if.in_valid = 1'b0;
    lat = 3;
    while (u_if.out_valid !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    n_cmp++;
    if (u_if.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_valid got %b want 1", u_if.out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (u_if.out_valid !== 1'b0 || u_if.out_data !== 64'h0) begin
      n_bad++; $display("FAIL rst_mid got %b/%h want 0/0", u_if.out_valid, u_if.out_data);
    end
    n_cmp++;
    if (u_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_in_ready got %b want 1", u_if.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    for (int c = 0; c < 12; c++) begin
      if (u_if.out_valid !== 1'b0) stray++;
      cycle();
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL rst_stale got %0d valid cycles want 0", stray);
    end
    send_wait(1'b0, 64'h0001020304050607, 1'b1, od, ot, lat);
    n_cmp++;
    if (lat != 8) begin
      n_bad++; $display("FAIL rst_after_latency got %0d want 8", lat);
    end
    n_cmp++;
    if (od !== 64'h0001020304050607) begin
      n_bad++; $display("FAIL rst_after_data got %h want 0001020304050607", od);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_desc = 1'b0; u_if.in_data = '0; u_if.out_ready = 1'b1;
    s_if.in_valid = 1'b0; s_if.in_desc = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b1;
    test_reset();
    test_sort_basic();
    test_stability();
    test_signed();
    cycle();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
